id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly downstream of the register file.
- Captures register read data (busA/busB), register specifiers, immediate and decoded control into the EX-side pipeline register.
- Resolves the destination register using the same RegDst rule as the write port: Rd when RegDst=1, else Rt.
- Detects load-use hazards and inserts bubbles, handles flush and external hold, and keeps a saturating bubble counter.

---
 rtl/mips_pkg.sv | 18 +
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS ID/EX slice: control-bundle field indices
// and the default register-specifier and control widths.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // Bit positions inside the decoded control bundle.
  localparam int REGWR    = 0;
  localparam int REGDST   = 1;
  localparam int MEMRD    = 2;
  localparam int MEMWR    = 3;
  localparam int MEMTOREG = 4;
  localparam int ALUSRC   = 5;
  localparam int ALUOP_LO = 6;
  localparam int ALUOP_HI = 7;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// an in-flight load in EX is about to produce. Purely combinational.
module hazard_detect #(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_memrd,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              load_use
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // A load targeting r0 writes nothing, so it can never create a dependency.
  assign ex_is_load = ex_valid && ex_memrd && (ex_rw != '0);
  assign rs_match   = (ex_rw == id_rs);
  // Rt only matters when the instruction actually sources it (not for I-type
  // instructions where Rt is the destination).
  assign rt_match   = id_uses_rt && (ex_rw == id_rt);
  assign load_use   = ex_is_load && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, external
// hold and a saturating bubble counter.
// Optional macro ID_WB_BYPASS_EN: forward the WB write data into the captured
// operands to cover the regfile's write-at-edge/read-old-value window.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_busA,
  input  logic [DATA_W-1:0] id_busB,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              wb_regwr,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_busA,
  output logic [DATA_W-1:0] ex_busB,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rw,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              load_use;
  logic [DATA_W-1:0] cap_busA;
  logic [DATA_W-1:0] cap_busB;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_valid   (ex_valid),
    .ex_memrd   (ex_ctrl[MEMRD]),
    .ex_rw      (ex_rw),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // Upstream only freezes when this stage will really insert the bubble;
  // flush discards the ID instruction anyway and hold freezes everything.
  assign hazard_stall = load_use && !flush && !hold;

`ifdef ID_WB_BYPASS_EN
  // Operand select: take WB data when it writes the register being read.
  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
    cap_busA = id_busA;
    cap_busB = id_busB;
    if (wb_regwr && (wb_rw != '0) && (wb_rw == id_rs)) cap_busA = wb_data;
    if (wb_regwr && (wb_rw != '0) && (wb_rw == id_rt)) cap_busB = wb_data;
  end
`else
  assign cap_busA = id_busA;
  assign cap_busB = id_busB;

  // WB ports stay on the interface but carry no function in this build.
  logic unused_wb;
  assign unused_wb = ^{wb_regwr, wb_rw, wb_data};
`endif

  // EX pipeline register: reset, hold, flush, load-use bubble, then capture.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (arst) begin
      ex_valid   <= 1'b0;
      ex_busA    <= '0;
      ex_busB    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rw      <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else if (hold) begin
      // Everything keeps its value; hold outranks flush and hazards.
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (load_use) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_busA  <= cap_busA;
      ex_busB  <= cap_busB;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rw    <= id_ctrl[REGDST] ? id_rd : id_rt;
      ex_imm   <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. A second instance with a
// 3-bit bubble counter shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  // lw: REGWR|MEMRD|MEMTOREG|ALUSRC ; add: REGWR|REGDST|ALUOP=10 ; addi: REGWR|ALUSRC
  localparam logic [CTRL_W-1:0] C_LW   = 8'h35;
  localparam logic [CTRL_W-1:0] C_ADD  = 8'h83;
  localparam logic [CTRL_W-1:0] C_ADDI = 8'h21;

  logic              clk = 1'b0;
  logic              arst;
  logic              id_valid;
  logic [DATA_W-1:0] id_busA, id_busB, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_uses_rt;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, hold;
  logic              wb_regwr;
  logic [REG_AW-1:0] wb_rw;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_busA, ex_busB, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rw;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              hazard_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              s_ex_valid;
  logic [DATA_W-1:0] s_ex_busA, s_ex_busB, s_ex_imm;
  logic [REG_AW-1:0] s_ex_rs, s_ex_rt, s_ex_rw;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic              s_hazard_stall;
  logic [2:0]        s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_busA(id_busA), .id_busB(id_busB),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .wb_regwr(wb_regwr), .wb_rw(wb_rw),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_busA(id_busA), .id_busB(id_busB),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .wb_regwr(wb_regwr), .wb_rw(wb_rw),
    .wb_data(wb_data), .ex_valid(s_ex_valid), .ex_busA(s_ex_busA), .ex_busB(s_ex_busB),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rw(s_ex_rw), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .hazard_stall(s_hazard_stall), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                          input logic [REG_AW-1:0] rd, input logic urt, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm,
                          input logic [CTRL_W-1:0] ctrl);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rt = urt;
    id_busA    = a;
    id_busB    = b;
    id_imm     = imm;
    id_ctrl    = ctrl;
    #1;
  endtask

  logic [DATA_W-1:0] exp_byp_a, exp_byp_b;

  initial begin
    arst = 1'b1; flush = 1'b0; hold = 1'b0;
    wb_regwr = 1'b0; wb_rw = '0; wb_data = '0;

    // Reset with random ID inputs.
    drive_id(1'b1, REG_AW'($urandom), REG_AW'($urandom), REG_AW'($urandom), 1'b1,
             $urandom, $urandom, $urandom, C_LW);
    tick();
    drive_id(1'b1, REG_AW'($urandom), REG_AW'($urandom), REG_AW'($urandom), 1'b1,
             $urandom, $urandom, $urandom, C_LW);
    tick();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_ctrl",  64'(ex_ctrl),  64'd0);
    check("rst_busA",  64'(ex_busA),  64'd0);
    check("rst_busB",  64'(ex_busB),  64'd0);
    check("rst_rw",    64'(ex_rw),    64'd0);
    check("rst_imm",   64'(ex_imm),   64'd0);
    check("rst_cnt",   64'(bubble_cnt), 64'd0);
    check("rst_stall", 64'(hazard_stall), 64'd0);
    arst = 1'b0;

    // lw r5 <- (r1): RegDst=0 so destination is Rt.
    drive_id(1'b1, 5'd1, 5'd5, 5'd9, 1'b0, 32'h100, 32'h200, 32'h10, C_LW);
    check("lw_no_stall", 64'(hazard_stall), 64'd0);
    tick();
    check("lw_valid", 64'(ex_valid), 64'd1);
    check("lw_rw",    64'(ex_rw),    64'd5);
    check("lw_ctrl",  64'(ex_ctrl),  64'(C_LW));
    check("lw_busA",  64'(ex_busA),  64'h100);
    check("lw_imm",   64'(ex_imm),   64'h10);
    check("lw_rs",    64'(ex_rs),    64'd1);
    check("lw_rt",    64'(ex_rt),    64'd5);

    // add r8 <- r5 + r3: load-use on Rs.
    drive_id(1'b1, 5'd5, 5'd3, 5'd8, 1'b1, 32'hA, 32'hB, 32'h0, C_ADD);
    check("lu_rs_stall", 64'(hazard_stall), 64'd1);
    tick();
    check("lu_bub_valid", 64'(ex_valid), 64'd0);
    check("lu_bub_ctrl",  64'(ex_ctrl),  64'd0);
    check("lu_cnt1",      64'(bubble_cnt), 64'd1);
    check("lu_stall_clr", 64'(hazard_stall), 64'd0);
    tick();
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_rw",    64'(ex_rw),    64'd8);
    check("add_ctrl",  64'(ex_ctrl),  64'(C_ADD));
    check("add_busA",  64'(ex_busA),  64'hA);
    check("add_busB",  64'(ex_busB),  64'hB);
    check("add_stall", 64'(hazard_stall), 64'd0);

    // Rt gating against lw r6.
    drive_id(1'b1, 5'd2, 5'd6, 5'd0, 1'b0, 32'h0, 32'h0, 32'h4, C_LW);
    tick();
    check("lw6_rw", 64'(ex_rw), 64'd6);
    drive_id(1'b1, 5'd4, 5'd6, 5'd0, 1'b0, 32'h0, 32'h0, 32'h1, C_ADDI);
    check("rt_unused_no_stall", 64'(hazard_stall), 64'd0);
    id_uses_rt = 1'b1; #1;
    check("rt_used_stall", 64'(hazard_stall), 64'd1);

    // Flush on top of the hazard: no stall, bubble captured, counter untouched.
    flush = 1'b1; #1;
    check("flush_no_stall", 64'(hazard_stall), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_ctrl",  64'(ex_ctrl),  64'd0);
    check("flush_cnt",   64'(bubble_cnt), 64'd1);

    // lw targeting r0 never stalls.
    drive_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    check("lw0_valid", 64'(ex_valid), 64'd1);
    drive_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
    check("r0_no_stall", 64'(hazard_stall), 64'd0);
    tick();
    check("r0_captured", 64'(ex_rw), 64'd12);

    // Hold with a live hazard: EX frozen for 3 cycles, no stall, no count.
    drive_id(1'b1, 5'd1, 5'd7, 5'd0, 1'b0, 32'h1111, 32'h2222, 32'h3333, C_LW);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      drive_id(i[0], 5'd7, 5'(i + 20), 5'(i + 1), 1'b1, 32'(i + 5), 32'(i + 6), 32'(i + 7), C_ADD);
      check("hold_no_stall", 64'(hazard_stall), 64'd0);
      tick();
      check("hold_valid", 64'(ex_valid), 64'd1);
      check("hold_rw",    64'(ex_rw),    64'd7);
      check("hold_busA",  64'(ex_busA),  64'h1111);
      check("hold_imm",   64'(ex_imm),   64'h3333);
      check("hold_ctrl",  64'(ex_ctrl),  64'(C_LW));
      check("hold_cnt",   64'(bubble_cnt), 64'd1);
    end
    hold = 1'b0; flush = 1'b0;
    drive_id(1'b1, 5'd7, 5'd2, 5'd13, 1'b1, 32'h77, 32'h88, 32'h0, C_ADD);
    check("rel_stall", 64'(hazard_stall), 64'd1);
    tick();
    check("rel_cnt", 64'(bubble_cnt), 64'd2);
    tick();
    check("rel_valid", 64'(ex_valid), 64'd1);
    check("rel_rw",    64'(ex_rw),    64'd13);
    check("rel_busA",  64'(ex_busA),  64'h77);

    // WB bypass window.
`ifdef ID_WB_BYPASS_EN
    exp_byp_a = 32'hDEADBEEF;
`else
    exp_byp_a = 32'h1;
`endif
    wb_regwr = 1'b1; wb_rw = 5'd7; wb_data = 32'hDEADBEEF;
    drive_id(1'b1, 5'd7, 5'd3, 5'd14, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
    tick();
    check("byp_busA", 64'(ex_busA), 64'(exp_byp_a));
    check("byp_busB_nomatch", 64'(ex_busB), 64'h2);
`ifdef ID_WB_BYPASS_EN
    exp_byp_b = 32'hDEADBEEF;
`else
    exp_byp_b = 32'h2;
`endif
    wb_rw = 5'd3;
    drive_id(1'b1, 5'd4, 5'd3, 5'd14, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
    tick();
    check("byp_busB", 64'(ex_busB), 64'(exp_byp_b));
    check("byp_busA_nomatch", 64'(ex_busA), 64'h1);
    wb_rw = 5'd0;
    drive_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
    tick();
    check("byp_r0_busA", 64'(ex_busA), 64'h1);
    wb_regwr = 1'b0;

    // Invalid ID slot captures a bubble even with nonzero control.
    drive_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h5, 32'h6, 32'h7, C_LW);
    tick();
    check("inv_valid", 64'(ex_valid), 64'd0);
    check("inv_ctrl",  64'(ex_ctrl),  64'd0);

    // Six more load-use bubbles: 16-bit counter reaches 8, 3-bit one saturates at 7.
    for (int i = 0; i < 6; i++) begin
      drive_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
      tick();
      drive_id(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
      tick();
      tick();
    end
    check("sat_cnt16", 64'(bubble_cnt), 64'd8);
    check("sat_cnt3",  64'(s_bubble_cnt), 64'd7);
    drive_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive_id(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
    check("sat_stall", 64'(s_hazard_stall), 64'd1);
    tick();
    check("sat_hold7", 64'(s_bubble_cnt), 64'd7);
    check("sat_cnt9",  64'(bubble_cnt), 64'd9);

    // Reset in mid-stall.
    drive_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    drive_id(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
    check("mid_stall", 64'(hazard_stall), 64'd1);
    arst = 1'b1;
    tick();
    check("mid_rst_stall", 64'(hazard_stall), 64'd0);
    check("mid_rst_valid", 64'(ex_valid), 64'd0);
    check("mid_rst_cnt",   64'(bubble_cnt), 64'd0);
    arst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
